// File: rtl/ifu_fetchq_if.sv
// ifu_fetchq_if
// Bundles every non-clock, non-reset signal of the instruction fetch unit:
//   - execute redirect inputs (redir_*, immediates, opA_i)
//   - instruction-memory request/response handshake (imem_*)
//   - decode-side queue head (instr_*) and the misalign flag
// Modports:
//   master : the fetch unit itself
//   slave  : the surrounding execute/memory/decode environment
interface ifu_fetchq_if;
   logic        redir_valid_i;
   logic [6:0]  redir_opcode_i;
   logic        redir_taken_i;
   logic [31:0] redir_pc_i;
   logic [31:0] itypeimm_i;
   logic [31:0] sbtypeimm_i;
   logic [31:0] ujtypeimm_i;
   logic [31:0] opA_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        misalign_o;

   modport master (
      input  redir_valid_i, redir_opcode_i, redir_taken_i, redir_pc_i,
      input  itypeimm_i, sbtypeimm_i, ujtypeimm_i, opA_i,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output misalign_o
   );

   modport slave (
      output redir_valid_i, redir_opcode_i, redir_taken_i, redir_pc_i,
      output itypeimm_i, sbtypeimm_i, ujtypeimm_i, opA_i,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  misalign_o
   );
endinterface

// File: rtl/ifu_fetchq.sv
// ifu_fetchq
// Instruction fetch unit: PC generator, single-outstanding instruction-memory
// handshake and a QDEPTH-entry instruction queue feeding decode. Redirects
// (taken branch, JAL, JALR) flush the queue and discard any in-flight response.
// Ports:
//   clk_i   : sole clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : ifu_fetchq_if.master (redirect, imem handshake, decode queue head)
// Parameters:
//   RESET_PC : first fetch address after reset
//   QDEPTH   : queue entries, power of 2, at least 2
// Optional feature macro: IFU_MISALIGN_CHK_EN
//   defined   : a misaligned redirect target halts fetch and raises misalign_o
//   undefined : target[1:0] forced to 0, misalign_o tied low
module ifu_fetchq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 4
) (
   input logic          clk_i,
   input logic          reset_i,
   ifu_fetchq_if.master bus
);
   localparam int unsigned      PTR_W    = $clog2(QDEPTH);
   localparam int unsigned      CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [6:0]       OP_BRANCH = 7'h63;
   localparam logic [6:0]       OP_JAL    = 7'h6f;
   localparam logic [6:0]       OP_JALR   = 7'h67;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_e;

   state_e           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             discard_q, discard_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      q_instr_q [QDEPTH];
   logic [31:0]      q_pc_q    [QDEPTH];

   logic             redir_fire;
   logic [31:0]      target_raw;
   logic [31:0]      target;
   logic             push;
   logic             pop;
   logic             instr_valid;

`ifdef IFU_MISALIGN_CHK_EN
   logic             misalign_q, misalign_d;
`endif

   // Redirect decode and target. JALR clears bit 0 like the ISA requires;
   // the low two bits are either checked or forced depending on the build.
   always_comb begin
      redir_fire = bus.redir_valid_i &&
                   ((bus.redir_opcode_i == OP_JAL) ||
                    (bus.redir_opcode_i == OP_JALR) ||
                    ((bus.redir_opcode_i == OP_BRANCH) && bus.redir_taken_i));
      case (bus.redir_opcode_i)
         OP_JAL:  target_raw = bus.redir_pc_i + bus.ujtypeimm_i;
         OP_JALR: target_raw = (bus.opA_i + bus.itypeimm_i) & ~32'h1;
         default: target_raw = bus.redir_pc_i + bus.sbtypeimm_i;
      endcase
`ifdef IFU_MISALIGN_CHK_EN
      target = target_raw;
`else
      target = {target_raw[31:2], 2'b00};
`endif
   end

   // Next-state logic: the FSM and queue bookkeeping first, then a redirect
   // overrides pointers, count and state since it outranks push and pop.
   // In WAIT the free-slot test includes this cycle's push so that a request
   // is only issued when its response is guaranteed a queue entry.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      push       = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      instr_valid = (count_q != '0);
      pop         = instr_valid && bus.instr_ready_i;

      case (state_q)
         IDLE: begin
            if (count_q < QDEPTH_C) state_d = REQ;
         end
         REQ: begin
            if (bus.imem_gnt_i) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid_i) begin
               push      = !discard_q;
               discard_d = 1'b0;
               if ((count_q + (push ? CNT_ONE : '0)) < QDEPTH_C) state_d = REQ;
               else                                              state_d = IDLE;
            end
         end
         default: begin
            count_d = '0;
         end
      endcase

      if (state_q != HALT) begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      end

      if (redir_fire && (state_q != HALT)) begin
         fetch_pc_d = target;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         push       = 1'b0;
         case (state_q)
            REQ: begin
               if (bus.imem_gnt_i) begin
                  state_d   = WAIT;
                  discard_d = 1'b1;
               end else begin
                  state_d   = REQ;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid_i) begin
                  state_d   = REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end
            default: state_d = REQ;
         endcase
`ifdef IFU_MISALIGN_CHK_EN
         if (target[1:0] != 2'b00) begin
            state_d    = HALT;
            misalign_d = 1'b1;
         end
`endif
      end
   end

   // State registers with synchronous reset; reset drops any in-flight
   // response simply by returning to REQ with the discard flag cleared.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= REQ;
         fetch_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
`ifdef IFU_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
`ifdef IFU_MISALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Queue storage. The outstanding request's address is fetch_pc - 4 because
   // fetch_pc advances on grant and only one request is ever outstanding.
   always_ff @(posedge clk_i) begin
      if (push && !reset_i) begin
         q_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
         q_pc_q[wr_ptr_q]    <= fetch_pc_q - 32'd4;
      end
   end

   // The request is masked during reset so memory sees it withdrawn there.
   assign bus.imem_req_o    = (state_q == REQ) && !reset_i;
   assign bus.imem_addr_o   = fetch_pc_q;
   assign bus.instr_valid_o = instr_valid;
   assign bus.instr_o       = instr_valid ? q_instr_q[rd_ptr_q] : 32'h0;
   assign bus.instr_pc_o    = instr_valid ? q_pc_q[rd_ptr_q]    : 32'h0;
`ifdef IFU_MISALIGN_CHK_EN
   assign bus.misalign_o    = misalign_q;
`else
   assign bus.misalign_o    = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetchq.sv
// tb_ifu_fetchq
// Directed bench for ifu_fetchq with RESET_PC=0x100, QDEPTH=4. A small memory
// responder grants whenever imem_gnt_i is high and returns addr ^ 0xA5A50000
// one cycle after each grant.
module tb_ifu_fetchq;
   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ifu_fetchq_if bus ();

   ifu_fetchq #(.RESET_PC(32'h100), .QDEPTH(4)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // Memory model: one response per accepted request, one cycle later.
   always @(posedge clk) begin
      bus.imem_rvalid_i <= bus.imem_req_o && bus.imem_gnt_i && !reset;
      if (bus.imem_req_o && bus.imem_gnt_i) bus.imem_rdata_i <= bus.imem_addr_o ^ MAGIC;
   end

   // Advance one clock and settle past the edge before looking at outputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [6:0] op, input logic taken,
                                input logic [31:0] pc, input logic [31:0] iimm,
                                input logic [31:0] sbimm, input logic [31:0] ujimm,
                                input logic [31:0] opa);
      bus.redir_valid_i  = valid;
      bus.redir_opcode_i = op;
      bus.redir_taken_i  = taken;
      bus.redir_pc_i     = pc;
      bus.itypeimm_i     = iimm;
      bus.sbtypeimm_i    = sbimm;
      bus.ujtypeimm_i    = ujimm;
      bus.opA_i          = opa;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      bus.imem_gnt_i    = 1'b1;
      bus.instr_ready_i = 1'b0;
      tick();
      checkOutput("rst_req", {31'h0, bus.imem_req_o}, 32'h0);
      checkOutput("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("rst_addr", bus.imem_addr_o, 32'h100);
      checkOutput("rst_misalign", {31'h0, bus.misalign_o}, 32'h0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("first_req", {31'h0, bus.imem_req_o}, 32'h1);
      checkOutput("first_addr", bus.imem_addr_o, 32'h100);
      checkOutput("first_instr", bus.instr_o, 32'h0);
   endtask

   initial begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
      bus.imem_gnt_i    = 1'b1;
      bus.instr_ready_i = 1'b0;
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Sequential fetch, consumer always ready: one instruction every 2 cycles.
      doReset();
      bus.instr_ready_i = 1'b1;
      tick();
      checkOutput("seq_e1_req", {31'h0, bus.imem_req_o}, 32'h0);
      checkOutput("seq_e1_addr", bus.imem_addr_o, 32'h104);
      tick();
      checkOutput("seq_e2_valid", {31'h0, bus.instr_valid_o}, 32'h1);
      checkOutput("seq_e2_pc", bus.instr_pc_o, 32'h100);
      checkOutput("seq_e2_instr", bus.instr_o, 32'h100 ^ MAGIC);
      checkOutput("seq_e2_addr", bus.imem_addr_o, 32'h104);
      tick();
      checkOutput("seq_e3_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("seq_e3_addr", bus.imem_addr_o, 32'h108);
      tick();
      checkOutput("seq_e4_pc", bus.instr_pc_o, 32'h104);
      tick();
      tick();
      checkOutput("seq_e6_pc", bus.instr_pc_o, 32'h108);

      // Fill with consumer stalled: 4 pushes then IDLE, one pop reissues 0x110.
      doReset();
      repeat (8) tick();
      checkOutput("fill_valid", {31'h0, bus.instr_valid_o}, 32'h1);
      checkOutput("fill_head", bus.instr_pc_o, 32'h100);
      checkOutput("fill_req", {31'h0, bus.imem_req_o}, 32'h0);
      tick();
      checkOutput("fill_idle_req", {31'h0, bus.imem_req_o}, 32'h0);
      checkOutput("fill_idle_addr", bus.imem_addr_o, 32'h110);
      bus.instr_ready_i = 1'b1;
      tick();
      bus.instr_ready_i = 1'b0;
      checkOutput("fill_pop_head", bus.instr_pc_o, 32'h104);
      checkOutput("fill_pop_req", {31'h0, bus.imem_req_o}, 32'h0);
      tick();
      checkOutput("fill_reissue_req", {31'h0, bus.imem_req_o}, 32'h1);
      checkOutput("fill_reissue_addr", bus.imem_addr_o, 32'h110);

      // Taken branch while the 0x100 response is arriving: it must be dropped.
      doReset();
      tick();
      applyStimulus(1'b1, 7'h63, 1'b1, 32'h200, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("br_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("br_req", {31'h0, bus.imem_req_o}, 32'h1);
      checkOutput("br_addr", bus.imem_addr_o, 32'h1F8);
      tick();
      checkOutput("br_e3_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      tick();
      checkOutput("br_e4_pc", bus.instr_pc_o, 32'h1F8);
      checkOutput("br_e4_instr", bus.instr_o, 32'h1F8 ^ MAGIC);

      // JALR in REQ without grant; then untaken branch and foreign opcode ignored.
      doReset();
      bus.imem_gnt_i = 1'b0;
      applyStimulus(1'b1, 7'h67, 1'b0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h1001);
      tick();
      checkOutput("jalr_req", {31'h0, bus.imem_req_o}, 32'h1);
      checkOutput("jalr_addr", bus.imem_addr_o, 32'h1004);
      bus.imem_gnt_i = 1'b1;
      applyStimulus(1'b1, 7'h63, 1'b0, 32'h200, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h0);
      tick();
      checkOutput("nt_addr", bus.imem_addr_o, 32'h1008);
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      checkOutput("nt_pc", bus.instr_pc_o, 32'h1004);
      checkOutput("nt_req", {31'h0, bus.imem_req_o}, 32'h1);
      applyStimulus(1'b1, 7'h33, 1'b1, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("badop_addr", bus.imem_addr_o, 32'h100C);

      // Redirect coinciding with push and pop on a half-full queue.
      doReset();
      repeat (5) tick();
      bus.instr_ready_i = 1'b1;
      applyStimulus(1'b1, 7'h6f, 1'b0, 32'h300, 32'h0, 32'h0, 32'h40, 32'h0);
      tick();
      bus.instr_ready_i = 1'b0;
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("pp_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("pp_addr", bus.imem_addr_o, 32'h340);
      tick();
      tick();
      checkOutput("pp_pc", bus.instr_pc_o, 32'h340);

      // Redirect in REQ with grant: the granted 0x344 response is discarded.
      applyStimulus(1'b1, 7'h6f, 1'b0, 32'h400, 32'h0, 32'h0, 32'h8, 32'h0);
      tick();
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("disc_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("disc_addr", bus.imem_addr_o, 32'h408);
      tick();
      checkOutput("disc_drop_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      checkOutput("disc_req", {31'h0, bus.imem_req_o}, 32'h1);
      tick();
      tick();
      checkOutput("disc_pc", bus.instr_pc_o, 32'h408);

      // JAL to a misaligned target.
      doReset();
      applyStimulus(1'b1, 7'h6f, 1'b0, 32'h500, 32'h0, 32'h0, 32'h2, 32'h0);
      tick();
      applyStimulus(1'b0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef IFU_MISALIGN_CHK_EN
      checkOutput("mis_flag", {31'h0, bus.misalign_o}, 32'h1);
      checkOutput("mis_req", {31'h0, bus.imem_req_o}, 32'h0);
      repeat (3) tick();
      checkOutput("mis_hold_flag", {31'h0, bus.misalign_o}, 32'h1);
      checkOutput("mis_hold_req", {31'h0, bus.imem_req_o}, 32'h0);
      checkOutput("mis_hold_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      doReset();
`else
      checkOutput("mis_flag", {31'h0, bus.misalign_o}, 32'h0);
      checkOutput("mis_addr", bus.imem_addr_o, 32'h500);
      tick();
      checkOutput("mis_req", {31'h0, bus.imem_req_o}, 32'h1);
      checkOutput("mis_addr2", bus.imem_addr_o, 32'h500);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
